// File: rtl/pixel_layer_arbiter_pkg.sv
// Shared types and constants for the pixel layer arbiter.
package pixel_layer_arbiter_pkg;

  typedef enum logic [1:0] {
    MODE_RUN   = 2'd0,
    MODE_FLASH = 2'd1,
    MODE_DARK  = 2'd2
  } mode_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb24_t;

  localparam logic [7:0] BG_R = 8'hFF;
  localparam logic [7:0] BG_G = 8'hFF;
  localparam logic [7:0] BG_B = 8'h7F;

endpackage

// File: rtl/pixel_layer_arbiter_prio.sv
// layer_priority_enc: lowest-index set bit wins; valid flags any hit.
module layer_priority_enc
  import pixel_layer_arbiter_pkg::*;
#(
  parameter int NUM_LAYERS = 4,
  parameter int IDX_W      = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic [NUM_LAYERS-1:0] hit,
  output logic [IDX_W-1:0]      idx,
  output logic                  valid
);

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int unsigned i = NUM_LAYERS; i > 0; i--) begin
      if (hit[i-1]) begin
        idx   = IDX_W'(i - 1);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pixel_layer_arbiter.sv
// Two-stage sprite layer arbiter with RUN/FLASH/DARK frame modes.
// Define GRADIENT_BG_EN for a DrawX-dependent blue background gradient.
module pixel_layer_arbiter
  import pixel_layer_arbiter_pkg::*;
#(
  parameter int NUM_LAYERS   = 4,
  parameter int FLASH_FRAMES = 8
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     frame_start,
  input  logic [9:0]               DrawX,
  input  logic [9:0]               DrawY,
  input  logic [NUM_LAYERS-1:0]    layer_hit,
  input  logic [NUM_LAYERS*24-1:0] layer_color,
  input  logic                     game_over,
  input  logic                     restart,
  output logic [7:0]               VGA_R,
  output logic [7:0]               VGA_G,
  output logic [7:0]               VGA_B,
  output logic [1:0]               mode
);

  localparam int IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int CNT_W = $clog2(FLASH_FRAMES) + 1;
  localparam logic [CNT_W-1:0] LAST_FRAME = CNT_W'(FLASH_FRAMES - 1);

  mode_t            state;
  logic [CNT_W-1:0] frame_cnt;
  logic             phase;
  logic             pending;

  logic [IDX_W-1:0] win_idx;
  logic             win_valid;
  rgb24_t           win_color;

  logic             s1_live;
  logic             s1_valid;
  logic [IDX_W-1:0] s1_idx;
  rgb24_t           s1_color;
  logic [7:0]       bg_b;
  logic [23:0]      base_c;
  logic [23:0]      out_c;
  logic             unused_coord;

  layer_priority_enc #(
    .NUM_LAYERS(NUM_LAYERS),
    .IDX_W     (IDX_W)
  ) u_prio (
    .hit  (layer_hit),
    .idx  (win_idx),
    .valid(win_valid)
  );

  assign win_color = layer_color[24*win_idx +: 24];
  assign mode      = state;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= MODE_RUN;
      frame_cnt <= '0;
      phase     <= 1'b0;
      pending   <= 1'b0;
    end else if (frame_start) begin
      if (restart || pending) begin
        state     <= MODE_RUN;
        frame_cnt <= '0;
        phase     <= 1'b0;
        pending   <= 1'b0;
      end else begin
        case (state)
          MODE_RUN: if (game_over) begin
            state     <= MODE_FLASH;
            frame_cnt <= '0;
            phase     <= 1'b1;
          end
          MODE_FLASH: if (frame_cnt == LAST_FRAME) begin
            state <= MODE_DARK;
          end else begin
            frame_cnt <= frame_cnt + 1'b1;
            phase     <= ~phase;
          end
          default: ;
        endcase
      end
    end else if (restart) begin
      pending <= 1'b1;
    end
  end

  // s1_live marks stage 1 as holding a real pixel, so output stays black until refilled
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      s1_live  <= 1'b0;
      s1_valid <= 1'b0;
      s1_idx   <= '0;
      s1_color <= '0;
    end else begin
      s1_live  <= 1'b1;
      s1_valid <= win_valid;
      s1_idx   <= win_idx;
      s1_color <= win_color;
    end
  end

`ifdef GRADIENT_BG_EN
  logic [6:0] s1_x;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) s1_x <= '0;
    else        s1_x <= DrawX[9:3];
  end

  assign bg_b         = BG_B - {1'b0, s1_x};
  assign unused_coord = ^{DrawY, DrawX[2:0]};
`else
  assign bg_b         = BG_B;
  assign unused_coord = ^{DrawY, DrawX};
`endif

  always_comb begin
    base_c = s1_valid ? s1_color : {BG_R, BG_G, bg_b};
    out_c  = base_c;
    case (state)
      MODE_FLASH: if (phase) out_c = ~base_c;
      MODE_DARK:  if (!(s1_valid && s1_idx == '0)) out_c = '0;
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      {VGA_R, VGA_G, VGA_B} <= '0;
    end else begin
      {VGA_R, VGA_G, VGA_B} <= s1_live ? out_c : '0;
    end
  end

endmodule

// File: tb/tb_pixel_layer_arbiter.sv
// Randomized self-checking bench for pixel_layer_arbiter with a frame-level reference model.
module tb_pixel_layer_arbiter;

  localparam int NL = 4;
  localparam int FF = 8;

  logic           Clk = 1'b0;
  logic           Reset = 1'b0;
  logic           frame_start = 1'b0;
  logic [9:0]     DrawX = '0;
  logic [9:0]     DrawY = '0;
  logic [NL-1:0]  layer_hit = '0;
  logic [NL*24-1:0] layer_color = '0;
  logic           game_over = 1'b0;
  logic           restart = 1'b0;
  logic [7:0]     VGA_R, VGA_G, VGA_B;
  logic [1:0]     mode;

  int total = 0;
  int bad   = 0;

  // reference model: mode 0/1/2, flash frames shown, inversion, pending restart
  int m_mode    = 0;
  int m_frames  = 0;
  bit m_inv     = 1'b0;
  bit m_pending = 1'b0;

  logic [NL*24-1:0] cols;

  pixel_layer_arbiter #(
    .NUM_LAYERS  (NL),
    .FLASH_FRAMES(FF)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_start(frame_start),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .layer_hit  (layer_hit),
    .layer_color(layer_color),
    .game_over  (game_over),
    .restart    (restart),
    .VGA_R      (VGA_R),
    .VGA_G      (VGA_G),
    .VGA_B      (VGA_B),
    .mode       (mode)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] bg_at(input int x);
`ifdef GRADIENT_BG_EN
    return {16'hFFFF, 8'(127 - x / 8)};
`else
    return 24'hFFFF7F;
`endif
  endfunction

  function automatic logic [23:0] ref_pixel(input logic [NL-1:0] hit,
                                            input logic [NL*24-1:0] col, input int x);
    int win = -1;
    logic [23:0] c;
    for (int i = NL - 1; i >= 0; i--) if (hit[i]) win = i;
    c = (win < 0) ? bg_at(x) : col[win*24 +: 24];
    if (m_mode == 1 && m_inv) c = ~c;
    if (m_mode == 2 && win != 0) c = '0;
    return c;
  endfunction

  task automatic frame(input bit go, input bit rs);
    game_over = go;
    restart = rs;
    frame_start = 1'b1;
    @(posedge Clk); #1;
    frame_start = 1'b0;
    restart = 1'b0;
    if (rs || m_pending) begin
      m_mode = 0;
      m_pending = 1'b0;
    end else if (m_mode == 0) begin
      if (go) begin
        m_mode = 1;
        m_frames = 0;
        m_inv = 1'b1;
      end
    end else if (m_mode == 1) begin
      if (m_frames == FF - 1) m_mode = 2;
      else begin
        m_frames++;
        m_inv = !m_inv;
      end
    end
    check_eq("mode", {30'd0, mode}, m_mode);
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(posedge Clk); #1;
    restart = 1'b0;
    m_pending = 1'b1;
  endtask

  task automatic pixel(input string tag, input logic [NL-1:0] hit,
                       input logic [NL*24-1:0] col, input int x, input logic [23:0] exp);
    layer_hit = hit;
    layer_color = col;
    DrawX = 10'(x);
    DrawY = 10'($urandom_range(0, 479));
    repeat (2) @(posedge Clk);
    #1;
    check_eq(tag, {8'd0, VGA_R, VGA_G, VGA_B}, {8'd0, exp});
  endtask

  task automatic random_pixels(input int n);
    logic [NL-1:0] h;
    logic [NL*24-1:0] c;
    int x;
    for (int i = 0; i < n; i++) begin
      h = ($urandom_range(0, 3) == 0) ? '0 : NL'($urandom);
      c = {$urandom, $urandom, $urandom};
      x = $urandom_range(0, 639);
      pixel("rand", h, c, x, ref_pixel(h, c, x));
    end
  endtask

  initial begin
    cols = {24'h0000FF, 24'hFF0000, 24'h00FF00, 24'h123456};

    #12;
    check_eq("reset_vga", {8'd0, VGA_R, VGA_G, VGA_B}, 32'd0);
    check_eq("reset_mode", {30'd0, mode}, 32'd0);
    layer_hit = 4'b0010;
    layer_color = cols;
    Reset = 1'b1;
    @(posedge Clk); #1;
    check_eq("flush_vga", {8'd0, VGA_R, VGA_G, VGA_B}, 32'd0);

    pixel("run_prio", 4'b0110, cols, 0, 24'h00FF00);
    pixel("bg_320", 4'b0000, cols, 320, bg_at(320));
`ifdef GRADIENT_BG_EN
    pixel("bg_320_const", 4'b0000, cols, 320, 24'hFFFF57);
    pixel("bg_639", 4'b0000, cols, 639, 24'hFFFF30);
`else
    pixel("bg_320_const", 4'b0000, cols, 320, 24'hFFFF7F);
`endif
    pixel("bg_0", 4'b0000, cols, 0, 24'hFFFF7F);
    random_pixels(20);

    frame(1'b0, 1'b0);
    frame(1'b1, 1'b0);
    check_eq("enter_flash", {30'd0, mode}, 32'd1);
    for (int k = 0; k < FF; k++) begin
      pixel("flash_px", 4'b0110, cols, 100, (k % 2 == 0) ? 24'hFF00FF : 24'h00FF00);
      random_pixels(3);
      frame(1'b1, 1'b0);
    end
    check_eq("enter_dark", {30'd0, mode}, 32'd2);

    pixel("dark_l0", 4'b0001, cols, 50, 24'h123456);
    pixel("dark_l0_multi", 4'b0101, cols, 50, 24'h123456);
    pixel("dark_l2", 4'b0100, cols, 50, 24'h000000);
    pixel("dark_bg", 4'b0000, cols, 50, 24'h000000);
    random_pixels(10);
    frame(1'b1, 1'b0);

    pulse_restart();
    repeat (3) @(posedge Clk);
    #1;
    frame(1'b1, 1'b0);
    check_eq("restart_from_dark", {30'd0, mode}, 32'd0);

    frame(1'b1, 1'b0);
    pulse_restart();
    frame(1'b1, 1'b0);
    check_eq("restart_over_go", {30'd0, mode}, 32'd0);
    frame(1'b1, 1'b0);
    frame(1'b1, 1'b1);
    check_eq("restart_same_cycle", {30'd0, mode}, 32'd0);

    pulse_restart();
    frame(1'b1, 1'b0);
    frame(1'b1, 1'b0);
    random_pixels(10);
    frame(1'b0, 1'b0);
    frame(1'b0, 1'b0);
    random_pixels(10);

    // mid-frame asynchronous reset while flashing
    pixel("pre_reset", 4'b0010, cols, 10, ref_pixel(4'b0010, cols, 10));
    #2;
    Reset = 1'b0;
    #1;
    check_eq("async_vga", {8'd0, VGA_R, VGA_G, VGA_B}, 32'd0);
    check_eq("async_mode", {30'd0, mode}, 32'd0);
    m_mode = 0;
    m_frames = 0;
    m_inv = 1'b0;
    m_pending = 1'b0;
    #3;
    Reset = 1'b1;
    @(posedge Clk); #1;
    check_eq("reflush_vga", {8'd0, VGA_R, VGA_G, VGA_B}, 32'd0);
    check_eq("resume_mode", {30'd0, mode}, 32'd0);
    frame(1'b0, 1'b0);
    pixel("resume_px", 4'b0110, cols, 0, 24'h00FF00);
    random_pixels(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
